pwm_edge_scheduler: RTL
=======================

Name: pwm_edge_scheduler

Overview:
Converts per-transducer (CYCLE, DUTY, PHASE) settings into PWM edge times LEFT/RIGHT inside [0, CYCLE-1], plus an OVER (wrap) flag, for the PWM generators. It generalises the single-lane centred preconditioner in three ways: LANES transducers are processed per clock, there is a selectable left-aligned mode, and there is a BUSY/DONE handshake with asynchronous reset. It sits between the register/modulation stage and the per-transducer PWM counters.

Parameters:
WIDTH, 13, bit width of cycle/duty/phase/edge values
DEPTH, 249, number of transducers
LANES, 1, transducers computed per clock (1..DEPTH; DEPTH need not be a multiple)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
UPDATE  in  1  start request; sampled only in IDLE
MODE  in  1  0 = centred, 1 = left-aligned; captured with UPDATE
CYCLE  in  [WIDTH-1:0] x DEPTH  period per transducer
DUTY  in  [WIDTH-1:0] x DEPTH  on-time
PHASE  in  [WIDTH-1:0] x DEPTH  phase
BUSY  out  1  high while processing
DONE  out  1  one-cycle pulse when all outputs are valid
OVER  out  1 x DEPTH  1 = pulse wraps (RIGHT < LEFT region)
LEFT  out  [WIDTH-1:0] x DEPTH  rising-edge time
RIGHT  out  [WIDTH-1:0] x DEPTH  falling-edge time

Behaviour:
- Clocking and reset: one clock CLK; RST is asynchronous, active-high.
- On RST: state IDLE; BUSY=0; DONE=0; all OVER/LEFT/RIGHT=0. Asserting RST mid-operation aborts the run and clears everything.
- States: IDLE -> RUN on UPDATE=1 at edge E0. RUN -> IDLE at the edge writing the last batch. There are no other states.
- At E0, CYCLE/DUTY/PHASE/MODE are snapshotted. Later input changes do not affect the run.
- UPDATE while BUSY=1 is ignored and not queued.
- Batches: NB = ceil(DEPTH/LANES). Batch b covers indices b*LANES .. b*LANES+LANES-1. Lanes past DEPTH-1 are computed but discarded.
- Pipeline is 3 registered stages per lane:
  - S1 (E0+1+b): P = (PHASE==0) ? 0 : CYCLE-PHASE. Centred: dl=floor(D/2), dr=ceil(D/2). Left-aligned: dl=0, dr=D.
  - S2 (E0+2+b): l = P-dl, r = P+dr.
  - S3 (E0+3+b): fold and write outputs (see below).
- Fold rule:
  - if l<0: LEFT=l+CYCLE, RIGHT=r, OVER=1.
  - else if r>=CYCLE: LEFT=l, RIGHT=r-CYCLE, OVER=1.
  - else: LEFT=l, RIGHT=r, OVER=0.
- Arithmetic is signed WIDTH+2 internally. Outputs are the low WIDTH bits.
- Input precondition: PHASE<CYCLE, DUTY<=CYCLE, CYCLE>=1. Results outside the precondition are unspecified, but the FSM must still terminate.
- BUSY rises at E0+1 and falls together with DONE.
- DONE=1 for exactly one cycle, registered at E0+2+NB, the same edge the last batch is written. Example: DEPTH=249, LANES=1 gives DONE at E0+251.
- Outputs not yet rewritten hold their previous values. UPDATE in the same cycle DONE is high is accepted (back-to-back runs).

Optional Feature:
PWM_EDGE_SCHEDULER_SHADOW_EN:
- Defined: results go to internal shadow registers. OVER/LEFT/RIGHT all update atomically at the DONE edge, so outputs never show a mixed old/new set.
- Undefined: no shadow storage. Batches update outputs progressively as specified above.

Decomposition:
- Package pwm_edge_pkg:
  - mode_t enum {MODE_CENTRED, MODE_LEFT}
  - PIPE_LATENCY=3
  - function num_batches(depth, lanes)
- Sub-module pwm_edge_lane: one lane's 3-stage S1-S3 pipeline, instantiated LANES times via generate.
- The top level keeps the FSM, batch counter, snapshot, and output/shadow registers.

Test Plan:
- Centred, CYCLE=4096, PHASE=0, DUTY=2048 -> LEFT=3072, RIGHT=1024, OVER=1.
- Centred, CYCLE=4096, PHASE=1024, DUTY=1025 -> LEFT=2560, RIGHT=3585, OVER=0.
- Left-aligned, CYCLE=4096, PHASE=1000, DUTY=3500 -> LEFT=3096, RIGHT=2500, OVER=1.
- Latency:
  - DEPTH=249, LANES=1 -> single DONE pulse at E0+251.
  - LANES=4 -> DONE at E0+65.
  - DEPTH=10, LANES=4 -> DONE at E0+5, and indices 0..9 all correct.
- UPDATE pulsed every cycle during RUN -> no restart and exactly one DONE. RST at E0+50 -> BUSY=0 and all outputs 0 immediately, with no DONE.
- With SHADOW_EN: a mid-run sample shows old values everywhere, and all new values appear at the DONE edge. Without it, index 0 changes at E0+3.

Source files
------------

// File: rtl/pwm_edge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pwm_edge_pkg                                                    |
// | Brief    : Shared types, constants and helpers for the PWM edge scheduler. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package pwm_edge_pkg;

    typedef enum logic [0:0] {
        MODE_CENTRED = 1'b0,
        MODE_LEFT    = 1'b1
    } mode_t;

    localparam int PIPE_LATENCY = 3;

    function automatic int num_batches(input int depth, input int lanes);
        return (depth + lanes - 1) / lanes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_edge_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pwm_edge_lane                                                   |
// | Brief    : One lane of edge computation: S1/S2 registers plus the S3 fold, |
// |            whose result is registered by the parent's output stage.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pwm_edge_lane
    import pwm_edge_pkg::*;
#(
    parameter int WIDTH = 13
)
(
    input  logic             clk,
    input  logic             rst,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] cycle,
    input  logic [WIDTH-1:0] duty,
    input  logic [WIDTH-1:0] phase,
    output logic             over,
    output logic [WIDTH-1:0] left,
    output logic [WIDTH-1:0] right
);

    localparam int SW = WIDTH + 2;

    logic signed [SW-1:0] cyc_ext;
    logic signed [SW-1:0] duty_ext;
    logic signed [SW-1:0] phase_ext;

    logic signed [SW-1:0] p_d,    p_q;
    logic signed [SW-1:0] dl_d,   dl_q;
    logic signed [SW-1:0] dr_d,   dr_q;
    logic signed [SW-1:0] cyc1_d, cyc1_q;

    logic signed [SW-1:0] l_d,    l_q;
    logic signed [SW-1:0] r_d,    r_q;
    logic signed [SW-1:0] cyc2_d, cyc2_q;

    logic signed [SW-1:0] left_full;
    logic signed [SW-1:0] right_full;
    logic                 unused_hi;

    always_comb begin
        cyc_ext   = $signed({2'b00, cycle});
        duty_ext  = $signed({2'b00, duty});
        phase_ext = $signed({2'b00, phase});
        p_d       = (phase == '0) ? '0 : (cyc_ext - phase_ext);
        cyc1_d    = cyc_ext;
        if (mode == MODE_LEFT) begin
            dl_d = '0;
            dr_d = duty_ext;
        end else begin
            // Odd duty puts the extra tick on the falling side.
            dl_d = $signed({3'b000, duty[WIDTH-1:1]});
            dr_d = duty_ext - $signed({3'b000, duty[WIDTH-1:1]});
        end
    end

    always_comb begin
        l_d    = p_q - dl_q;
        r_d    = p_q + dr_q;
        cyc2_d = cyc1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q    <= '0;
            dl_q   <= '0;
            dr_q   <= '0;
            cyc1_q <= '0;
            l_q    <= '0;
            r_q    <= '0;
            cyc2_q <= '0;
        end else begin
            p_q    <= p_d;
            dl_q   <= dl_d;
            dr_q   <= dr_d;
            cyc1_q <= cyc1_d;
            l_q    <= l_d;
            r_q    <= r_d;
            cyc2_q <= cyc2_d;
        end
    end

    always_comb begin
        left_full  = l_q;
        right_full = r_q;
        over       = 1'b0;
        if (l_q[SW-1]) begin
            left_full = l_q + cyc2_q;
            over      = 1'b1;
        end else if (r_q >= cyc2_q) begin
            right_full = r_q - cyc2_q;
            over       = 1'b1;
        end
        left  = left_full[WIDTH-1:0];
        right = right_full[WIDTH-1:0];
    end

    assign unused_hi = ^{left_full[SW-1:WIDTH], right_full[SW-1:WIDTH]};

endmodule
`default_nettype wire

// File: rtl/pwm_edge_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pwm_edge_scheduler                                              |
// | Brief    : Batched PWM edge scheduler with BUSY/DONE handshake. Define     |
// |            PWM_EDGE_SCHEDULER_SHADOW_EN to publish all edges atomically    |
// |            at DONE instead of batch by batch.                              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pwm_edge_scheduler
    import pwm_edge_pkg::*;
#(
    parameter int WIDTH = 13,
    parameter int DEPTH = 249,
    parameter int LANES = 1
)
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             UPDATE,
    input  logic             MODE,
    input  logic [WIDTH-1:0] CYCLE [0:DEPTH-1],
    input  logic [WIDTH-1:0] DUTY  [0:DEPTH-1],
    input  logic [WIDTH-1:0] PHASE [0:DEPTH-1],
    output logic             BUSY,
    output logic             DONE,
    output logic [DEPTH-1:0] OVER,
    output logic [WIDTH-1:0] LEFT  [0:DEPTH-1],
    output logic [WIDTH-1:0] RIGHT [0:DEPTH-1]
);

    localparam int NB = num_batches(DEPTH, LANES);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [BW-1:0] LAST_BATCH = BW'(NB - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             start;
    logic             last_write;
    mode_t            mode_q,  mode_d;

    logic [WIDTH-1:0] snap_cycle_q [0:DEPTH-1];
    logic [WIDTH-1:0] snap_cycle_d [0:DEPTH-1];
    logic [WIDTH-1:0] snap_duty_q  [0:DEPTH-1];
    logic [WIDTH-1:0] snap_duty_d  [0:DEPTH-1];
    logic [WIDTH-1:0] snap_phase_q [0:DEPTH-1];
    logic [WIDTH-1:0] snap_phase_d [0:DEPTH-1];

    logic [BW-1:0]    feed_q, feed_d;
    logic             feed_act_q, feed_act_d;
    logic             v1_q, v1_d, v2_q, v2_d;
    logic [BW-1:0]    b1_q, b1_d, b2_q, b2_d;

    logic             lane_over  [0:LANES-1];
    logic [WIDTH-1:0] lane_left  [0:LANES-1];
    logic [WIDTH-1:0] lane_right [0:LANES-1];

    logic [DEPTH-1:0] tgt_over_q,  tgt_over_d;
    logic [WIDTH-1:0] tgt_left_q  [0:DEPTH-1];
    logic [WIDTH-1:0] tgt_left_d  [0:DEPTH-1];
    logic [WIDTH-1:0] tgt_right_q [0:DEPTH-1];
    logic [WIDTH-1:0] tgt_right_d [0:DEPTH-1];

    assign start      = (state_q == ST_IDLE) && UPDATE;
    assign last_write = v2_q && (b2_q == LAST_BATCH);

    // FSM: state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (UPDATE)     state_d = ST_RUN;
            ST_RUN:  if (last_write) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs, registered so BUSY rises one edge after the start edge
    always_comb begin
        busy_d = (state_q == ST_RUN) && !last_write;
        done_d = last_write;
    end

    assign BUSY = busy_q;
    assign DONE = done_q;

    always_comb begin
        mode_d = mode_q;
        if (start) begin
            mode_d       = MODE ? MODE_LEFT : MODE_CENTRED;
            snap_cycle_d = CYCLE;
            snap_duty_d  = DUTY;
            snap_phase_d = PHASE;
        end else begin
            snap_cycle_d = snap_cycle_q;
            snap_duty_d  = snap_duty_q;
            snap_phase_d = snap_phase_q;
        end
    end

    // Batch issue counter and the valid/batch tags that follow S1 and S2.
    always_comb begin
        feed_d     = feed_q;
        feed_act_d = feed_act_q;
        if (start) begin
            feed_d     = '0;
            feed_act_d = 1'b1;
        end else if (feed_act_q) begin
            if (feed_q == LAST_BATCH) begin
                feed_act_d = 1'b0;
            end else begin
                feed_d = feed_q + BW'(1);
            end
        end
        v1_d = feed_act_q;
        b1_d = feed_q;
        v2_d = v1_q;
        b2_d = b1_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q       <= MODE_CENTRED;
            snap_cycle_q <= '{default: '0};
            snap_duty_q  <= '{default: '0};
            snap_phase_q <= '{default: '0};
            feed_q       <= '0;
            feed_act_q   <= 1'b0;
            v1_q         <= 1'b0;
            b1_q         <= '0;
            v2_q         <= 1'b0;
            b2_q         <= '0;
        end else begin
            mode_q       <= mode_d;
            snap_cycle_q <= snap_cycle_d;
            snap_duty_q  <= snap_duty_d;
            snap_phase_q <= snap_phase_d;
            feed_q       <= feed_d;
            feed_act_q   <= feed_act_d;
            v1_q         <= v1_d;
            b1_q         <= b1_d;
            v2_q         <= v2_d;
            b2_q         <= b2_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [WIDTH-1:0] in_cycle;
        logic [WIDTH-1:0] in_duty;
        logic [WIDTH-1:0] in_phase;

        // Lanes beyond DEPTH-1 in the final batch see zeros and are never written.
        always_comb begin
            in_cycle = '0;
            in_duty  = '0;
            in_phase = '0;
            for (int b = 0; b < NB; b++) begin
                if (((b * LANES + l) < DEPTH) && (feed_q == BW'(b))) begin
                    in_cycle = snap_cycle_q[AW'(b * LANES + l)];
                    in_duty  = snap_duty_q[AW'(b * LANES + l)];
                    in_phase = snap_phase_q[AW'(b * LANES + l)];
                end
            end
        end

        pwm_edge_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk   (CLK),
            .rst   (RST),
            .mode  (mode_q),
            .cycle (in_cycle),
            .duty  (in_duty),
            .phase (in_phase),
            .over  (lane_over[l]),
            .left  (lane_left[l]),
            .right (lane_right[l])
        );
    end

    always_comb begin
        tgt_over_d  = tgt_over_q;
        tgt_left_d  = tgt_left_q;
        tgt_right_d = tgt_right_q;
        for (int d = 0; d < DEPTH; d++) begin
            if (v2_q && (b2_q == BW'(d / LANES))) begin
                tgt_over_d[AW'(d)]  = lane_over[LW'(d % LANES)];
                tgt_left_d[AW'(d)]  = lane_left[LW'(d % LANES)];
                tgt_right_d[AW'(d)] = lane_right[LW'(d % LANES)];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tgt_over_q  <= '0;
            tgt_left_q  <= '{default: '0};
            tgt_right_q <= '{default: '0};
        end else begin
            tgt_over_q  <= tgt_over_d;
            tgt_left_q  <= tgt_left_d;
            tgt_right_q <= tgt_right_d;
        end
    end

`ifdef PWM_EDGE_SCHEDULER_SHADOW_EN
    logic [DEPTH-1:0] pub_over_q,  pub_over_d;
    logic [WIDTH-1:0] pub_left_q  [0:DEPTH-1];
    logic [WIDTH-1:0] pub_left_d  [0:DEPTH-1];
    logic [WIDTH-1:0] pub_right_q [0:DEPTH-1];
    logic [WIDTH-1:0] pub_right_d [0:DEPTH-1];

    // The final batch bypasses the shadow so the published set is complete at DONE.
    always_comb begin
        if (last_write) begin
            pub_over_d  = tgt_over_d;
            pub_left_d  = tgt_left_d;
            pub_right_d = tgt_right_d;
        end else begin
            pub_over_d  = pub_over_q;
            pub_left_d  = pub_left_q;
            pub_right_d = pub_right_q;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pub_over_q  <= '0;
            pub_left_q  <= '{default: '0};
            pub_right_q <= '{default: '0};
        end else begin
            pub_over_q  <= pub_over_d;
            pub_left_q  <= pub_left_d;
            pub_right_q <= pub_right_d;
        end
    end

    assign OVER  = pub_over_q;
    assign LEFT  = pub_left_q;
    assign RIGHT = pub_right_q;
`else
    assign OVER  = tgt_over_q;
    assign LEFT  = tgt_left_q;
    assign RIGHT = tgt_right_q;
`endif

endmodule
`default_nettype wire
